// File: rtl/hop_sequencer.sv
// Carrier-bin hop sequencer: sweeps or walks a hop table, dwelling
// a programmed number of clocks per bin with an optional silent gap.
module hop_sequencer #(
    parameter int TABLE_DEPTH = 16,
    parameter int CNT_W       = 24
) (
    input  logic             CLK,
    input  logic             reset_trigger,
    input  logic             cfg_we,
    input  logic [4:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             start,
    input  logic             stop,
    output logic [6:0]       bin_sel,
    output logic             tx_en,
    output logic             busy,
    output logic             hop_strobe,
    output logic             done,
    output logic             cfg_err
);

    localparam int IW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam logic [4:0] DEPTH5 = 5'(TABLE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL,
        GAP
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       mode_q;
    logic [6:0]       lo_q;
    logic [6:0]       hi_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] gap_q;
    logic [4:0]       len_q;
    logic [6:0]       tbl_q [TABLE_DEPTH];
    logic             err_q;

    logic [6:0]       pos_q, pos_d;
    logic [6:0]       bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hop_q, hop_d;
    logic             done_q, done_d;

    logic             tbl_mode;
    logic             loop_en;
    logic [4:0]       len_eff;
    logic [4:0]       last_idx;
    logic             is_last;
    logic [6:0]       first_pos;
    logic [6:0]       step_pos;
    logic [6:0]       adv_pos;
    logic [6:0]       first_bin;
    logic [6:0]       adv_bin;
    logic [CNT_W-1:0] dwell_ld;
    logic             advance;

    assign busy = (state_q != IDLE);

    always_ff @(posedge CLK or posedge reset_trigger) begin
        if (reset_trigger) begin
            mode_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            gap_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            err_q <= cfg_we && busy;
            if (cfg_we && !busy) begin
                case (cfg_addr)
                    5'd0: mode_q  <= cfg_wdata[1:0];
                    5'd1: lo_q    <= cfg_wdata[6:0];
                    5'd2: hi_q    <= cfg_wdata[6:0];
                    5'd3: dwell_q <= cfg_wdata;
                    5'd4: gap_q   <= cfg_wdata;
                    5'd5: len_q   <= cfg_wdata[4:0];
                    default: begin
                        if (cfg_addr[4] &&
                            ({1'b0, cfg_addr[3:0]} < DEPTH5)) begin
                            tbl_q[cfg_addr[IW-1:0]] <= cfg_wdata[6:0];
                        end
                    end
                endcase
            end
        end
    end

    assign tbl_mode = mode_q[0];
    assign loop_en  = mode_q[1];

    // Zero length means one entry; oversize lengths clamp to the table.
    assign len_eff  = (len_q == 5'd0) ? 5'd1 :
                      (len_q > DEPTH5) ? DEPTH5 : len_q;
    assign last_idx = len_eff - 5'd1;

    assign is_last   = tbl_mode ? (pos_q == {2'b00, last_idx})
                                : (pos_q == hi_q);
    assign first_pos = tbl_mode ? 7'd0 : lo_q;
    assign step_pos  = (tbl_mode || (lo_q <= hi_q)) ? pos_q + 7'd1
                                                     : pos_q - 7'd1;
    assign adv_pos   = is_last ? first_pos : step_pos;
    assign first_bin = tbl_mode ? tbl_q[first_pos[IW-1:0]] : first_pos;
    assign adv_bin   = tbl_mode ? tbl_q[adv_pos[IW-1:0]] : adv_pos;
    assign dwell_ld  = (dwell_q == '0) ? '0 : dwell_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        hop_d   = 1'b0;
        done_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pos_d   = first_pos;
                bin_d   = first_bin;
                hop_d   = 1'b1;
                cnt_d   = dwell_ld;
                state_d = DWELL;
            end
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (gap_q != '0) begin
                    cnt_d   = gap_q - CNT_W'(1);
                    state_d = GAP;
                end else begin
                    advance = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (is_last && !loop_en) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                pos_d   = adv_pos;
                bin_d   = adv_bin;
                hop_d   = 1'b1;
                cnt_d   = dwell_ld;
                state_d = DWELL;
            end
        end

        // Abort wins over everything, including a same-cycle start.
        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
            pos_d   = pos_q;
            bin_d   = bin_q;
            hop_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset_trigger) begin
        if (reset_trigger) begin
            state_q <= IDLE;
            pos_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            hop_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            hop_q   <= hop_d;
            done_q  <= done_d;
        end
    end

    assign bin_sel    = bin_q;
    assign tx_en      = (state_q == DWELL);
    assign hop_strobe = hop_q;
    assign done       = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_hop_sequencer.sv
// Scoreboard bench for hop_sequencer: stimulus queues expected hop/end
// events, a negedge monitor pops and checks them as the DUT emits them.
module tb_hop_sequencer;

    localparam int CNT_W = 24;

    logic             CLK = 1'b0;
    logic             reset_trigger;
    logic             cfg_we;
    logic [4:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;
    logic             start;
    logic             stop;
    logic [6:0]       bin_sel;
    logic             tx_en;
    logic             busy;
    logic             hop_strobe;
    logic             done;
    logic             cfg_err;

    hop_sequencer #(
        .TABLE_DEPTH(16),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK          (CLK),
        .reset_trigger(reset_trigger),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .start        (start),
        .stop         (stop),
        .bin_sel      (bin_sel),
        .tx_en        (tx_en),
        .busy         (busy),
        .hop_strobe   (hop_strobe),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int kind;
        int bin;
        int delta;
        int on;
        int dn;
    } ev_t;

    ev_t ev_q[$];
    ev_t me;
    int  checks  = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  err_exp = 0;
    int  last_ev = 0;
    int  on_cnt  = 0;
    logic busy_p = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void push_hop(int b, int d, int on);
        ev_t e;
        e.kind = 0; e.bin = b; e.delta = d; e.on = on; e.dn = 0;
        ev_q.push_back(e);
    endfunction

    function automatic void push_end(int dn, int d, int on);
        ev_t e;
        e.kind = 1; e.bin = -1; e.delta = d; e.on = on; e.dn = dn;
        ev_q.push_back(e);
    endfunction

    // Monitor: an event is a hop strobe or busy falling.
    always @(negedge CLK) begin
        if (reset_trigger) begin
            busy_p = 1'b0;
            on_cnt = 0;
        end else begin
            if (done && !(busy_p && !busy)) begin
                checks++; errors++;
                $display("FAIL stray_done at cycle %0d", cyc);
            end
            if (tx_en && !busy) begin
                checks++; errors++;
                $display("FAIL tx_idle tx_en=1 busy=0 cycle %0d", cyc);
            end
            if (hop_strobe || (busy_p && !busy)) begin
                if (ev_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event hop=%0d bin=%0d cyc=%0d",
                             hop_strobe, bin_sel, cyc);
                end else begin
                    me = ev_q.pop_front();
                    chk("ev_kind", hop_strobe ? 0 : 1, me.kind);
                    if (me.kind == 0) begin
                        chk("hop_bin", int'(bin_sel), me.bin);
                        chk("hop_tx", int'(tx_en), 1);
                    end else begin
                        chk("end_done", int'(done), me.dn);
                        chk("end_tx", int'(tx_en), 0);
                    end
                    if (me.delta >= 0) chk("ev_delta", cyc - last_ev, me.delta);
                    if (me.on >= 0) chk("tx_cycles", on_cnt, me.on);
                end
                last_ev = cyc;
                on_cnt  = 0;
            end
            if ((start && !stop && !busy) || (stop && busy)) begin
                last_ev = cyc;
                on_cnt  = 0;
            end
            if (cfg_err) begin
                checks++;
                if (err_exp == 0) begin
                    errors++;
                    $display("FAIL unexpected_cfg_err got 1 expected 0");
                end else begin
                    err_exp--;
                end
            end
            if (tx_en) on_cnt++;
            busy_p = busy;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cfg_addr  = 5'(a);
        cfg_wdata = CNT_W'(d);
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (ev_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (ev_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout pending=%0d expected 0", ev_q.size());
            ev_q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bin"},  int'(bin_sel),    0);
        chk({tag, "_tx"},   int'(tx_en),      0);
        chk({tag, "_busy"}, int'(busy),       0);
        chk({tag, "_hop"},  int'(hop_strobe), 0);
        chk({tag, "_done"}, int'(done),       0);
        chk({tag, "_err"},  int'(cfg_err),    0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_trigger = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk_zero("rst");
        reset_trigger = 1'b0;
        tick();

        // Defaults: single bin 0, dwell 0 acts as 1.
        push_hop(0, 2, 0);
        push_end(1, 1, 1);
        go();
        wait_empty(50);

        // Sweep up 3..6, dwell 10, gap 2, one shot.
        wr(1, 3); wr(2, 6); wr(3, 10); wr(4, 2); wr(0, 0);
        push_hop(3, 2, 0);
        for (int b = 4; b <= 6; b++) push_hop(b, 12, 10);
        push_end(1, 12, 10);
        go();
        wait_empty(200);
        chk("idle_hold_bin", int'(bin_sel), 6);

        // Sweep down 127..125 looping, contiguous dwell, then abort.
        wr(1, 127); wr(2, 125); wr(3, 4); wr(4, 0); wr(0, 2);
        push_hop(127, 2, 0);
        push_hop(126, 4, 4); push_hop(125, 4, 4);
        push_hop(127, 4, 4); push_hop(126, 4, 4);
        go();
        wait_empty(200);
        push_end(0, 1, -1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_empty(20);
        chk("stop_hold_bin", int'(bin_sel), 126);
        repeat (6) tick();

        // Hop table {9,0,64}, dwell 5.
        wr(16, 9); wr(17, 0); wr(18, 64);
        wr(5, 3); wr(3, 5); wr(0, 1);
        push_hop(9, 2, 0); push_hop(0, 5, 5); push_hop(64, 5, 5);
        push_end(1, 5, 5);
        go();
        wait_empty(100);

        // table_len 0 runs only entry 0.
        wr(5, 0);
        push_hop(9, 2, 0);
        push_end(1, 5, 5);
        go();
        wait_empty(50);

        // table_len 31 clamps to all 16 entries.
        for (int i = 3; i < 16; i++) wr(16 + i, 100 + i);
        wr(5, 31);
        push_hop(9, 2, 0); push_hop(0, 5, 5); push_hop(64, 5, 5);
        for (int i = 3; i < 16; i++) push_hop(100 + i, 5, 5);
        push_end(1, 5, 5);
        go();
        wait_empty(300);

        // Dwell write while busy is rejected.
        wr(5, 3);
        push_hop(9, 2, 0); push_hop(0, 5, 5); push_hop(64, 5, 5);
        push_end(1, 5, 5);
        go();
        tick(); tick();
        err_exp++;
        wr(3, 20);
        wait_empty(100);

        // start+stop together in IDLE does nothing.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        chk("ss_idle_busy", int'(busy), 0);
        chk("ss_idle_tx", int'(tx_en), 0);

        // start+stop together during DWELL aborts without done.
        push_hop(9, 2, 0);
        go();
        wait_empty(20);
        push_end(0, 1, -1);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        wait_empty(20);

        // Async reset mid-dwell clears outputs and config.
        wr(1, 10); wr(2, 12); wr(3, 3); wr(4, 1); wr(0, 2);
        push_hop(10, 2, 0);
        go();
        wait_empty(20);
        #2;
        chk("pre_rst_tx", int'(tx_en), 1);
        reset_trigger = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge CLK);
        #1;
        reset_trigger = 1'b0;
        ev_q.delete();
        err_exp = 0;
        tick();
        push_hop(0, 2, 0);
        push_end(1, 1, 1);
        go();
        wait_empty(50);

        repeat (8) tick();
        chk("err_drain", err_exp, 0);
        chk("queue_drain", ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hop_sequencer.md
Name: hop_sequencer

Overview:
- Time-sequences the 128-bin carrier bank (bin n = (n+1)*10 kHz): selects the active bin, gates transmission, and dwells for a programmed number of clocks per bin.
- Sits between the board control logic (switches/UART command decoder) and the carrier select mux that drives the PMOD antenna pin.
- Two modes: linear sweep between two bins (up or down), or hop table of up to TABLE_DEPTH entries; single-shot or looping.

Parameters:
TABLE_DEPTH, 16, number of hop-table entries (power of two, max 16)
CNT_W, 24, width of dwell/gap counters and cfg_wdata

Ports:
CLK  in  1  master clock (100 MHz)
reset_trigger  in  1  asynchronous active-high reset
cfg_we  in  1  config write strobe, one write per cycle
cfg_addr  in  5  config register address
cfg_wdata  in  CNT_W  config write data
start  in  1  single-cycle start request
stop  in  1  single-cycle abort request
bin_sel  out  7  active carrier bin index
tx_en  out  1  carrier gate, 1 = radiate
busy  out  1  sequence running
hop_strobe  out  1  1-cycle pulse when a new bin is applied
done  out  1  1-cycle pulse at single-shot completion
cfg_err  out  1  1-cycle pulse: write rejected

Behaviour:
- Reset: async assert, all registers cleared; bin_sel=0, tx_en=0, busy=0, hop_strobe=0, done=0, cfg_err=0; config registers 0 (mode, bins, dwell, gap, len, table entries).
- Config map: 0 mode (bit0 0=sweep 1=table, bit1 loop); 1 bin_lo[6:0]; 2 bin_hi[6:0]; 3 dwell[CNT_W-1:0]; 4 gap[CNT_W-1:0]; 5 table_len[4:0]; 16..16+TABLE_DEPTH-1 table entries [6:0]. Other addresses: write ignored, no error. Write takes effect next cycle.
- Writes while busy=1 are ignored and pulse cfg_err the following cycle.
- FSM states: IDLE, LOAD, DWELL, GAP.
- IDLE: busy=0, tx_en=0, bin_sel holds last value. start -> LOAD.
- LOAD (1 cycle): index <- 0 (table) or bin_lo (sweep); busy=1. -> DWELL.
- DWELL entry: bin_sel <- current bin, hop_strobe=1 on that same cycle, tx_en=1 for max(dwell,1) cycles. Latency start->tx_en high = 2 cycles.
- DWELL end: if gap!=0 -> GAP (tx_en=0 for gap cycles, bin_sel held) else advance directly.
- Advance: sweep steps +1 if bin_lo<=bin_hi, -1 otherwise; last bin = bin_hi. Table steps index+1; last index = max(table_len,1)-1, table_len > TABLE_DEPTH clamped to TABLE_DEPTH. After last bin: loop=1 -> restart from first bin (no LOAD cycle, direct DWELL entry); loop=0 -> IDLE, done pulse, tx_en=0 same cycle.
- bin_lo==bin_hi: single-bin sequence.
- stop (any non-IDLE state): next cycle IDLE, tx_en=0, busy=0, no done pulse. start and stop same cycle: stop wins. start while busy: ignored.
- Config registers are sampled live only for mode/bins at LOAD; dwell/gap/table read live (stable because writes blocked while busy).
- Counters: down-counters of CNT_W bits, no wrap; dwell=0 behaves as 1.
- Reset mid-sequence: immediate return to reset values, no done.

Test Plan:
- Reset then idle: assert reset_trigger mid-cycle -> all outputs 0 asynchronously; start with defaults -> bin_sel=0, tx_en high 1 cycle, done pulse, busy low.
- Sweep up: bin_lo=3, bin_hi=6, dwell=10, gap=2, loop=0 -> bin_sel 3,4,5,6, tx_en high 10 cycles/low 2 each, 4 hop_strobes, done once, tx_en first high 2 cycles after start.
- Sweep down looping: bin_lo=127, bin_hi=125, dwell=4, gap=0, loop=1 -> 127,126,125,127,... contiguous tx_en, no done; stop -> tx_en=0 and busy=0 next cycle.
- Table: entries {9,0,64}, table_len=3, dwell=5 -> bin_sel 9,0,64 each 5 cycles; table_len=0 -> only entry 0 (9); table_len=31 -> 16 entries.
- Write while busy to addr 3 -> cfg_err pulse, dwell unchanged for remaining hops.
- start and stop asserted same cycle in IDLE -> stays IDLE; same during DWELL -> abort, no done.
